// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding word request, configurable wait
// states, byte-masked read/write on an internal array, held response.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_s;
    logic               ready_r;
    logic               wr_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic [3:0]         be_r;
    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_err_r;
    logic               accept_s;
    logic               err_s;
    logic               do_write_s;
    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        mem_r [DEPTH];

    // Ready is held low for the whole time reset is asserted.
    assign req_ready  = ready_r & ~reset;
    assign accept_s   = req_valid & req_ready;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;

    // Misaligned or beyond-the-array accesses are rejected without touching memory.
    assign err_s      = (addr_r[1:0] != 2'b00) || ({2'b00, addr_r[31:2]} >= DEPTH_W);
    assign idx_s      = addr_r[IDX_W+1:2];
    assign do_write_s = (state_r == ST_ACCESS) && wr_r && !err_s && !reset;

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_INIT;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, request capture and held response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b1;
            wr_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_IDLE);
            if (accept_s) begin
                wr_r    <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                be_r    <= req_be;
            end
            if (state_r == ST_ACCESS) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= (!err_s && !wr_r) ? mem_r[idx_s] : 32'h0000_0000;
                rsp_err_r   <= err_s;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
                rsp_rdata_r <= 32'h0000_0000;
                rsp_err_r   <= 1'b0;
            end
        end
    end

    // Byte-masked array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 0 and 3 wait states) driven by
// directed transactions and checked every cycle against a transaction-level model.
module tb_mem_responder;

    localparam int WS [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        reset     [3];
    logic        req_valid [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_ready [3];
    logic        req_ready_w [3];
    logic        rsp_valid_w [3];
    logic [31:0] rsp_rdata_w [3];
    logic        rsp_err_w   [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model state per instance
    bit          m_init [3];
    bit          m_busy [3];
    bit          m_rv   [3];
    int          m_age  [3];
    bit          m_wr   [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_wd   [3];
    logic [3:0]  m_be   [3];
    logic [31:0] m_data [3];
    bit          m_err  [3];
    logic [31:0] mmem [int];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS[0])) u_dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata_w[0]), .rsp_err(rsp_err_w[0]));

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS[1])) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata_w[1]), .rsp_err(rsp_err_w[1]));

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS[2])) u_dut2 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready_w[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_be(req_be[2]), .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata_w[2]), .rsp_err(rsp_err_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level effect of an access: error rule, byte merge, read-back.
    task automatic model_access(input int d);
        logic [31:0] a;
        logic [31:0] w;
        int          key;
        a = m_addr[d];
        m_err[d]  = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
        m_data[d] = 32'h0;
        if (!m_err[d]) begin
            key = d * 2048 + int'(a[11:2]);
            w = mmem.exists(key) ? mmem[key] : 32'h0;
            if (m_wr[d]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[d][b]) w[8*b +: 8] = m_wd[d][8*b +: 8];
                mmem[key] = w;
            end else begin
                m_data[d] = w;
            end
        end
    endtask

    // Advance one clock: update the model at the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (reset[d]) begin
                m_init[d] = 1'b1;
                m_busy[d] = 1'b0;
                m_rv[d]   = 1'b0;
            end else if (m_init[d]) begin
                if (!m_busy[d]) begin
                    if (req_valid[d]) begin
                        m_busy[d] = 1'b1;
                        m_age[d]  = 0;
                        m_wr[d]   = req_write[d];
                        m_addr[d] = req_addr[d];
                        m_wd[d]   = req_wdata[d];
                        m_be[d]   = req_be[d];
                    end
                end else if (m_rv[d]) begin
                    if (rsp_ready[d]) begin
                        m_rv[d]   = 1'b0;
                        m_busy[d] = 1'b0;
                    end
                end else begin
                    m_age[d]++;
                    if (m_age[d] == WS[d] + 1) begin
                        model_access(d);
                        m_rv[d] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (m_init[d]) begin
                chk($sformatf("d%0d req_ready", d), req_ready_w[d], !reset[d] && !m_busy[d]);
                chk($sformatf("d%0d rsp_valid", d), rsp_valid_w[d], m_rv[d]);
                chk($sformatf("d%0d rsp_rdata", d), rsp_rdata_w[d], m_rv[d] ? m_data[d] : 32'h0);
                chk($sformatf("d%0d rsp_err", d), rsp_err_w[d], m_rv[d] ? m_err[d] : 1'b0);
            end
        end
    endtask

    // One complete transaction; hold = cycles the response is back-pressured.
    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int t;
        int acc;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        rsp_ready[d] = (hold == 0);
        t = 0;
        while (!req_ready_w[d] && t < 50) begin step(); t++; end
        chk("accept_timeout", t < 50, 1'b1);
        step();
        acc = cyc;
        req_valid[d] = 1'b0;
        req_write[d] = !wr;
        req_addr[d]  = a ^ 32'h4;
        req_wdata[d] = ~wd;
        req_be[d]    = ~be;
        t = 0;
        while (!rsp_valid_w[d] && t < 50) begin step(); t++; end
        chk("rsp_timeout", t < 50, 1'b1);
        lat = cyc - acc;
        rd  = rsp_rdata_w[d];
        er  = rsp_err_w[d];
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", rsp_valid_w[d], 1'b1);
            chk("hold_rdata", rsp_rdata_w[d], rd);
            chk("hold_ready", req_ready_w[d], 1'b0);
        end
        rsp_ready[d] = 1'b1;
        step();
        chk("rsp_drop", rsp_valid_w[d], 1'b0);
        chk("ready_back", req_ready_w[d], 1'b1);
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_c [4];
        int          rsp_c [4];
        int          na;
        int          nr;
        int          t;
        bit          pre_acc;
        bit          pre_rv;

        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
        end
        step();
        step();
        chk("reset_ready_low", req_ready_w[0], 1'b0);
        chk("reset_rsp_valid", rsp_valid_w[0], 1'b0);
        for (int d = 0; d < 3; d++) reset[d] = 1'b0;
        step();
        chk("ready_after_reset", req_ready_w[0], 1'b1);

        // basic write then read, one wait state
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("wr_lat", lat, 32'd2); chk("wr_rdata", rd, 32'h0); chk("wr_err", er, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
        chk("rd_lat", lat, 32'd2); chk("rd_rdata", rd, 32'hDEADBEEF); chk("rd_err", er, 1'b0);

        // byte-masked merge, then an all-zero mask as a no-op
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 0, rd, er, lat);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        chk("merge_rdata", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
        chk("be0_err", er, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        chk("be0_unchanged", rd, 32'h11BB33DD);

        // error cases and the last legal word
        txn(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0, rd, er, lat);
        txn(0, 1'b0, 32'h2, 32'h0, 4'hF, 0, rd, er, lat);
        chk("misalign_err", er, 1'b1); chk("misalign_rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk("range_err", er, 1'b1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat);
        chk("word0_kept", rd, 32'h01020304); chk("word0_err", er, 1'b0);
        txn(0, 1'b1, 32'hFFC, 32'h12345678, 4'hF, 0, rd, er, lat);
        txn(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 0, rd, er, lat);
        chk("last_word", rd, 32'h12345678); chk("last_word_err", er, 1'b0);

        // backpressure for five cycles
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);

        // zero wait states, request and response tied high
        txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        chk("ws0_wr_lat", lat, 32'd1);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h40; rsp_ready[1] = 1'b1;
        na = 0; nr = 0; t = 0;
        while ((na < 4 || nr < 4) && t < 60) begin
            pre_acc = req_ready_w[1] && req_valid[1];
            pre_rv  = rsp_valid_w[1];
            step();
            t++;
            if (pre_acc && na < 4) begin
                acc_c[na] = cyc; na++;
                if (na == 4) req_valid[1] = 1'b0;
            end
            if (!pre_rv && rsp_valid_w[1] && nr < 4) begin
                rsp_c[nr] = cyc; nr++;
                chk("stream_rdata", rsp_rdata_w[1], 32'hCAFEF00D);
            end
        end
        chk("stream_count", na * 16 + nr, 32'd68);
        for (int i = 0; i < 3; i++) chk("accept_spacing", acc_c[i+1] - acc_c[i], 32'd3);
        for (int i = 0; i < 4; i++) chk("stream_lat", rsp_c[i] - acc_c[i], 32'd1);
        step();
        rsp_ready[1] = 1'b0;

        // reset during WAIT abandons a write (three wait states)
        txn(2, 1'b1, 32'h30, 32'h00000055, 4'hF, 0, rd, er, lat);
        chk("ws3_lat", lat, 32'd4);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h30;
        req_wdata[2] = 32'hFFFFFFFF; req_be[2] = 4'hF; rsp_ready[2] = 1'b1;
        step();
        req_valid[2] = 1'b0;
        step();
        reset[2] = 1'b1;
        step();
        chk("midreset_ready_low", req_ready_w[2], 1'b0);
        reset[2] = 1'b0;
        step();
        chk("midreset_ready_high", req_ready_w[2], 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midreset_no_rsp", rsp_valid_w[2], 1'b0);
        end
        rsp_ready[2] = 1'b0;
        txn(2, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
        chk("midreset_kept", rd, 32'h00000055);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's word-addressed load/store/fetch port.
- Accepts one request at a time over a valid/ready handshake and waits a configurable number of cycles to model RAM or bus latency.
- Performs a byte-masked read or write on an internal word array, then returns a held response over a second valid/ready handshake.
- Replaces the zero-latency RAM so the pipeline control can be exercised against a slow memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; index = req_addr[31:2].
- WAIT_STATES, 1, extra cycles between request acceptance and array access; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator takes the response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; wait counter = 0.
  - req_ready = 0 while reset is high.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready = 1 (when reset is low).
  - Handshake = req_valid & req_ready at an edge.
  - On handshake, capture req_write, req_addr, req_wdata, req_be into internal registers.
  - Next state is WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else ACCESS.
- WAIT:
  - req_ready = 0; request inputs are ignored.
  - Counter decrements each cycle; when it reaches 0, next state is ACCESS.
  - Total time spent in WAIT is exactly WAIT_STATES cycles.
- ACCESS (one cycle), error check:
  - err = 1 if addr[1:0] != 0, or if addr[31:2] >= DEPTH.
  - On error: no array write; rdata = 0.
- ACCESS, read with no error: rdata = array[addr[31:2]].
- ACCESS, write with no error:
  - For each i with be[i] = 1, update byte i of array[addr[31:2]]; other bytes are unchanged.
  - be = 0000 is a legal no-op with err = 0.
  - rdata = 0.
- ACCESS exit: next state is RESP; rsp_valid, rsp_rdata and rsp_err are registered at this edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, next state IDLE.
  - rsp_ready while rsp_valid = 0 has no effect.
- Latency:
  - Request accepted at edge k ⇒ rsp_valid first high after edge k+WAIT_STATES+1.
  - Next req_ready occurs one cycle after the response handshake.
  - Back-to-back throughput is one transaction per WAIT_STATES+3 cycles with rsp_ready tied high.
- Ordering: strictly one outstanding transaction; a read after a write to the same word returns the merged data.
- Reset mid-transaction:
  - Asserted in WAIT: transaction is abandoned and no write occurs.
  - Asserted in RESP: the held response is dropped.
  - A write already performed in ACCESS is kept.
- req_valid high outside IDLE is ignored and does not queue.
- Change of req_* fields after acceptance has no effect (captured copy is used).

Test Plan:
- WAIT_STATES=1: write addr 0x10, wdata 0xDEADBEEF, be 1111; then read 0x10 → first rsp_valid 2 cycles after each accept edge; write rsp err=0, rdata=0; read rsp rdata=0xDEADBEEF, err=0.
- Byte-masked write: 0x11223344 to 0x20 with be 1111, then 0xAABBCCDD with be 0101; read 0x20 → rdata 0x11BB33DD.
- Errors with DEPTH=1024:
  - read 0x0000_0002 → err=1, rdata=0.
  - write 0x0000_1000 with be 1111 → err=1.
  - A follow-up read of word 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles with response pending → rsp_valid/rsp_rdata stable, req_ready=0 throughout; raise rsp_ready → rsp_valid drops next cycle and req_ready rises.
- WAIT_STATES=0 with req_valid and rsp_ready tied high: 4 reads → accepts spaced exactly 3 cycles apart, responses 1 cycle after each accept.
- Preload 0x55 at 0x30; issue write 0xFFFFFFFF to 0x30 and assert reset during WAIT (WAIT_STATES=3) → no response; after reset req_ready=1; read 0x30 returns 0x00000055.
